// File: rtl/fft16_pkg.sv
// Shared types, constants and helpers for the 16-point radix-2 DIT FFT.
// The optional FFT16_ROUND_EN build macro is consumed by fft16_butterfly.
package fft16_pkg;

    localparam int N          = 16;
    localparam int LOG2N      = 4;
    localparam int DATA_WIDTH = 16;
    localparam int Q          = 15;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

    // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), Q1.15. Unity is 32767 so the
    // constant stays inside the signed 16-bit range.
    localparam sample_t TW_RE [0:7] = '{
        16'sd32767,  16'sd30274,  16'sd23170,  16'sd12540,
        16'sd0,     -16'sd12540, -16'sd23170, -16'sd30274
    };
    localparam sample_t TW_IM [0:7] = '{
        16'sd0,     -16'sd12540, -16'sd23170, -16'sd30274,
       -16'sd32767, -16'sd30274, -16'sd23170, -16'sd12540
    };

    // Reverse the four index bits (time-order index -> stage-1 lane).
    function automatic logic [3:0] bitrev4(input logic [3:0] idx);
        return {idx[0], idx[1], idx[2], idx[3]};
    endfunction

    // Twiddle ROM lookup packed as a complex value.
    function automatic cplx_t twiddle(input int k);
        cplx_t w;
        w.re = TW_RE[k[2:0]];
        w.im = TW_IM[k[2:0]];
        return w;
    endfunction

endpackage

// File: rtl/fft16_butterfly.sv
// Combinational radix-2 DIT butterfly with a 1/2 scale on both outputs:
//   t  = (b * w) >>> 15            (17-bit)
//   y0 = (a + t) >>> 1,  y1 = (a - t) >>> 1   (18-bit sums, kept to 16 bits)
// Build macro FFT16_ROUND_EN: when defined, each shift rounds half-up
// (2^14 added before >>>15, 1 added before >>>1); otherwise plain floor.
module fft16_butterfly
    import fft16_pkg::*;
(
    input  cplx_t i_a,
    input  cplx_t i_b,
    input  cplx_t i_w,
    output cplx_t o_y0,
    output cplx_t o_y1
);

`ifdef FFT16_ROUND_EN
    localparam logic signed [32:0] RND_T = 33'sd16384;
    localparam logic signed [17:0] RND_Y = 18'sd1;
`else
    localparam logic signed [32:0] RND_T = 33'sd0;
    localparam logic signed [17:0] RND_Y = 18'sd0;
`endif

    // Partial products of b*w, each a full 32-bit signed product.
    logic signed [31:0] w_rr;
    logic signed [31:0] w_ii;
    logic signed [31:0] w_ri;
    logic signed [31:0] w_ir;

    // Product sums carry one guard bit so no combination can wrap.
    logic signed [32:0] w_p_re;
    logic signed [32:0] w_p_im;

    // Twiddled b back in Q1.15 with one extra integer bit.
    logic signed [16:0] w_t_re;
    logic signed [16:0] w_t_im;

    // Sum/difference at 18 bits before the halving shift.
    logic signed [17:0] w_s0_re;
    logic signed [17:0] w_s0_im;
    logic signed [17:0] w_s1_re;
    logic signed [17:0] w_s1_im;

    assign w_rr = 32'(i_b.re) * 32'(i_w.re);
    assign w_ii = 32'(i_b.im) * 32'(i_w.im);
    assign w_ri = 32'(i_b.re) * 32'(i_w.im);
    assign w_ir = 32'(i_b.im) * 32'(i_w.re);

    assign w_p_re = 33'(w_rr) - 33'(w_ii);
    assign w_p_im = 33'(w_ri) + 33'(w_ir);

    assign w_t_re = 17'((w_p_re + RND_T) >>> Q);
    assign w_t_im = 17'((w_p_im + RND_T) >>> Q);

    assign w_s0_re = 18'(i_a.re) + 18'(w_t_re) + RND_Y;
    assign w_s0_im = 18'(i_a.im) + 18'(w_t_im) + RND_Y;
    assign w_s1_re = 18'(i_a.re) - 18'(w_t_re) + RND_Y;
    assign w_s1_im = 18'(i_a.im) - 18'(w_t_im) + RND_Y;

    // The per-stage halving keeps valid data inside 16 bits, so the upper
    // bits are simply dropped.
    assign o_y0.re = 16'(w_s0_re >>> 1);
    assign o_y0.im = 16'(w_s0_im >>> 1);
    assign o_y1.re = 16'(w_s1_re >>> 1);
    assign o_y1.im = 16'(w_s1_im >>> 1);

endmodule

// File: rtl/fft_16_elements.sv
// 16-point radix-2 decimation-in-time FFT, fully parallel and pipelined.
// One frame per cycle in, bins in natural order out, scaled by 1/16.
// Samples are bit-reversed combinationally, then pass through four butterfly
// stages (spans 1, 2, 4, 8), each followed by one register rank. A frame
// driven with in_valid appears on fft_* with out_valid four edges later.
// There is no backpressure; the data ranks load on every edge and fft_* is
// only meaningful while out_valid is high.
// Build macro FFT16_ROUND_EN selects round-half-up arithmetic in every
// butterfly; latency is identical with or without it.
//
// Handshake: in_valid marks a frame on x_* for exactly the cycles it is
// high; out_valid marks the matching result on fft_*. Every accepted frame
// produces exactly one out_valid cycle, in order; nothing can stall.
module fft_16_elements
    import fft16_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] x_real   [N],
    input  logic signed [DATA_WIDTH-1:0] x_imag   [N],
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] fft_real [N],
    output logic signed [DATA_WIDTH-1:0] fft_imag [N]
);

    // Butterfly inputs and outputs per stage, and the stage register ranks.
    cplx_t            w_stage_in  [LOG2N][N];
    cplx_t            w_stage_out [LOG2N][N];
    cplx_t            r_stage     [LOG2N][N];
    logic [LOG2N-1:0] r_valid;

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage

        // Stage inputs: bit-reversed samples for stage 1, previous rank after.
        for (genvar i = 0; i < N; i++) begin : g_src
            if (s == 0) begin : g_perm
                localparam int SRC = int'(bitrev4(4'(i)));
                assign w_stage_in[s][i].re = x_real[SRC];
                assign w_stage_in[s][i].im = x_imag[SRC];
            end else begin : g_chain
                assign w_stage_in[s][i] = r_stage[s-1][i];
            end
        end

        // Eight butterflies per stage. Lane b sits at offset (b mod span) in
        // group (b / span); its partner is one span further on, and the
        // twiddle exponent steps by 8/span across the group.
        for (genvar b = 0; b < N / 2; b++) begin : g_bf
            localparam int    SPAN = 1 << s;
            localparam int    POS  = b % SPAN;
            localparam int    TOP  = ((b / SPAN) * 2 * SPAN) + POS;
            localparam int    BOT  = TOP + SPAN;
            localparam int    TWK  = POS << (LOG2N - 1 - s);
            localparam cplx_t W_K  = twiddle(TWK);

            fft16_butterfly u_bf (
                .i_a  (w_stage_in[s][TOP]),
                .i_b  (w_stage_in[s][BOT]),
                .i_w  (W_K),
                .o_y0 (w_stage_out[s][TOP]),
                .o_y1 (w_stage_out[s][BOT])
            );
        end
    end

    // Pipeline ranks and valid pipe; reset clears everything so no stale
    // frame can surface after a mid-stream reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int s = 0; s < LOG2N; s++) begin
                for (int i = 0; i < N; i++) begin
                    r_stage[s][i] <= '0;
                end
            end
        end else begin
            r_valid <= {r_valid[LOG2N-2:0], in_valid};
            for (int s = 0; s < LOG2N; s++) begin
                for (int i = 0; i < N; i++) begin
                    r_stage[s][i] <= w_stage_out[s][i];
                end
            end
        end
    end

    assign out_valid = r_valid[LOG2N-1];

    for (genvar i = 0; i < N; i++) begin : g_out
        assign fft_real[i] = r_stage[LOG2N-1][i].re;
        assign fft_imag[i] = r_stage[LOG2N-1][i].im;
    end

endmodule

// File: tb/tb_fft_16_elements.sv
// Testbench for fft_16_elements: table of frames with expected bins taken
// from a double-precision DFT/16, streamed through a scoreboard that also
// checks the four-edge latency, plus reset and streaming corner sequences.
`timescale 1ns/1ps
module tb_fft_16_elements;

    localparam int NPT      = 16;
    localparam int NV       = 11;
    localparam int LAT      = 4;
    localparam int SPEC_TOL = 4;
    localparam int RAND_TOL = 6;
`ifdef FFT16_ROUND_EN
    localparam int DC_TOL   = 2;
`else
    localparam int DC_TOL   = 4;
`endif
    localparam real PI = 3.14159265358979323846;

    typedef struct {
        int xr [NPT];
        int xi [NPT];
        int er [NPT];
        int ei [NPT];
        int tol;
    } vec_t;

    typedef struct {
        int er [NPT];
        int ei [NPT];
        int tol;
        int due;
        int id;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic               clk      = 1'b0;
    logic               rst_n    = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] x_real   [NPT];
    logic signed [15:0] x_imag   [NPT];
    logic               out_valid;
    logic signed [15:0] fft_real [NPT];
    logic signed [15:0] fft_imag [NPT];

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    fft_16_elements dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x_real    (x_real),
        .x_imag    (x_imag),
        .out_valid (out_valid),
        .fft_real  (fft_real),
        .fft_imag  (fft_imag)
    );

    // ---------------- scoreboard state ----------------
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frame_id = 0;
    exp_t exp_q [$];
    vec_t vecs [NV];

    // Reference: X[k] = (1/16) * sum x[n] * exp(-j*2*pi*n*k/16)
    function automatic void dft16(input int xr [NPT], input int xi [NPT],
                                  output int er [NPT], output int ei [NPT]);
        real th, sr, si;
        for (int k = 0; k < NPT; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < NPT; n++) begin
                th = 2.0 * PI * real'((n * k) % NPT) / real'(NPT);
                sr = sr + real'(xr[n]) * $cos(th) + real'(xi[n]) * $sin(th);
                si = si + real'(xi[n]) * $cos(th) - real'(xr[n]) * $sin(th);
            end
            er[k] = int'(sr / 16.0);
            ei[k] = int'(si / 16.0);
        end
    endfunction

    function automatic bit outputs_all_zero();
        for (int k = 0; k < NPT; k++) begin
            if (fft_real[k] !== 16'sd0 || fft_imag[k] !== 16'sd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < NPT; i++) begin
            x_real[i] = 16'(v.xr[i]);
            x_imag[i] = 16'(v.xi[i]);
        end
        in_valid = 1'b1;
        e.er  = v.er;
        e.ei  = v.ei;
        e.tol = v.tol;
        e.due = cycle + LAT;
        e.id  = frame_id;
        frame_id++;
        exp_q.push_back(e);
    endtask

    // Idle cycles carry junk data to show it never escapes without in_valid.
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int i = 0; i < NPT; i++) begin
                x_real[i] = 16'($urandom);
                x_imag[i] = 16'($urandom);
            end
        end
    endtask

    // ---------------- monitor / comparator ----------------
    exp_t mon_e;
    int   mon_bad;
    int   mon_dr;
    int   mon_di;

    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].due < cycle) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_frame id=%0d got=no out_valid by cycle %0d want=out_valid at cycle %0d",
                         exp_q[0].id, cycle, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_valid cycle=%0d got=1 want=0", cycle);
                end else if (exp_q[0].due != cycle) begin
                    n_fail++;
                    $display("FAIL latency id=%0d got=out_valid at cycle %0d want=cycle %0d",
                             exp_q[0].id, cycle, exp_q[0].due);
                    void'(exp_q.pop_front());
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_bad = -1;
                    for (int k = 0; k < NPT; k++) begin
                        mon_dr = int'(fft_real[k]) - mon_e.er[k];
                        mon_di = int'(fft_imag[k]) - mon_e.ei[k];
                        if (mon_dr < 0) mon_dr = -mon_dr;
                        if (mon_di < 0) mon_di = -mon_di;
                        if ((mon_dr > mon_e.tol || mon_di > mon_e.tol) && mon_bad < 0) mon_bad = k;
                    end
                    if (mon_bad >= 0) begin
                        n_fail++;
                        $display("FAIL frame_bins id=%0d bin=%0d got re=%0d im=%0d want re=%0d im=%0d tol=%0d",
                                 mon_e.id, mon_bad, fft_real[mon_bad], fft_imag[mon_bad],
                                 mon_e.er[mon_bad], mon_e.ei[mon_bad], mon_e.tol);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t v;
        int   stale;

        for (int i = 0; i < NPT; i++) begin
            x_real[i] = '0;
            x_imag[i] = '0;
        end

        // Vector table: inputs, then reference bins and tolerance.
        for (int t = 0; t < NV; t++) begin
            for (int n = 0; n < NPT; n++) begin
                v.xr[n] = 0;
                v.xi[n] = 0;
            end
            v.tol = SPEC_TOL;
            case (t)
                0: begin v.xr[0] = 16384; v.tol = 0; end                  // impulse, exact
                1: begin for (int n = 0; n < NPT; n++) v.xr[n] = 16384; v.tol = DC_TOL; end
                2: for (int n = 0; n < NPT; n++)                          // tone at bin 1
                       v.xr[n] = int'(16384.0 * $cos(2.0 * PI * real'(n) / 16.0));
                3: begin                                                  // odd-symmetric frame
                    v.xr[1]  = 12679;  v.xr[2]  = 8673;   v.xr[4]  = 992;
                    v.xr[5]  = 3547;   v.xr[7]  = -1451;  v.xr[8]  = 1451;
                    v.xr[10] = -3547;  v.xr[11] = -992;   v.xr[13] = -8673;
                    v.xr[14] = -12679;
                end
                4: for (int n = 0; n < NPT; n++) v.xr[n] = -32768;       // full-scale negative
                5: v.xi[1] = 16384;                                       // imaginary impulse, n=1
                6: v.xr[5] = -20000;                                      // real impulse, n=5
                default: begin                                            // random frames
                    for (int n = 0; n < NPT; n++) begin
                        v.xr[n] = int'($urandom_range(32767)) - 16384;
                        v.xi[n] = int'($urandom_range(32767)) - 16384;
                    end
                    v.tol = RAND_TOL;
                end
            endcase
            dft16(v.xr, v.xi, v.er, v.ei);
            vecs[t] = v;
        end

        // Reset: outputs must be zero while held.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || !outputs_all_zero()) begin
            n_fail++;
            $display("FAIL reset_state got out_valid=%b fft_real[0]=%0d want out_valid=0 and all bins 0",
                     out_valid, fft_real[0]);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Whole table back-to-back: outputs must stream on consecutive cycles.
        for (int t = 0; t < NV; t++) send(vecs[t]);
        idle(6);

        // Gapped frames.
        send(vecs[0]);
        idle(2);
        send(vecs[3]);
        idle(1);
        send(vecs[2]);
        idle(8);

        // Reset mid-stream: three frames in flight, the first one on the outputs.
        send(vecs[3]);
        send(vecs[4]);
        send(vecs[0]);
        idle(1);
        @(posedge clk);
        #2;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL prereset_valid got out_valid=%b want 1", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || !outputs_all_zero()) begin
            n_fail++;
            $display("FAIL async_reset_clear got out_valid=%b fft_real[0]=%0d want out_valid=0 and all bins 0",
                     out_valid, fft_real[0]);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // No stale frame may emerge after release.
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL stale_after_reset got %0d out_valid cycles want 0", stale);
        end

        // Normal operation resumes.
        send(vecs[0]);
        send(vecs[6]);
        idle(1);

        // Drain with a bounded wait.
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d frames outstanding want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
